stopwatch_timer: RTL and testbench
==================================

# stopwatch_timer

Parametrised BCD stopwatch/countdown timer driving four 7-segment digit nibbles on the board display path. It counts centiseconds from a configurable system clock. In up mode it auto-ranges from SS.cc to MM:SS. In countdown mode it runs down from a loaded MM:SS preset and raises an alarm at zero. An optional lap-freeze feature holds the display while counting continues.

## Interface
- `CLK_HZ`, 50_000_000, system clock frequency; `DIV = CLK_HZ/100` cycles per centisecond tick; `CLK_HZ` must be a multiple of 100 and ≥ 200.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `mode`  in  1  0 = up stopwatch, 1 = countdown; sampled only while stopped.
- `start_stop`  in  1  single-cycle pulse; toggles running.
- `clear`  in  1  single-cycle pulse; zeroes time, stops, clears flags.
- `load`  in  1  single-cycle pulse; loads preset (countdown, stopped only).
- `load_mm`  in  8  preset minutes, 2 BCD digits.
- `load_ss`  in  8  preset seconds, 2 BCD digits.
- `lap`  in  1  single-cycle pulse; lap freeze/release (macro-gated).
- `hex`  out  4x4  display digits; `hex[3]` is leftmost.
- `range`  out  1  0 = SS.cc shown, 1 = MM:SS shown.
- `running`  out  1  counter active.
- `alarm`  out  1  countdown reached 00:00.00; level.
- `overflow`  out  1  up count saturated at 59:59.99; level.
- `lap_active`  out  1  display frozen.

## Operation
- Internal time is held as BCD: `cs` 00-99, `sec` 00-59, `min` 00-59.
- Prescaler runs only while `running`. A tick fires when the prescaler equals DIV-1; the prescaler then wraps to 0. It holds its value when stopped, so resume is exact. `clear`, `load` and `rst` zero it.
- Up mode:
  - Each tick increments `cs`, carrying into `sec` and `min`.
  - A tick at 59:59.99 does not change the time. It clears `running` and sets `overflow`.
  - `start_stop` is ignored while `overflow`=1.
- Countdown mode:
  - Each tick decrements with borrow.
  - The tick that reaches 00:00.00 clears `running` and sets `alarm`.
  - `start_stop` at 00:00.00 is ignored; `alarm` stays as is.
- `load` is accepted only when stopped and mode=1; otherwise it is ignored.
  - Sets `min`=`load_mm` and `sec`=`load_ss`, each clamped to 59 if greater than 59, including invalid BCD. Sets `cs`=0 and clears `alarm`.
- `range` in up mode: 1 once `min`≥1. It stays 1 until `clear`.
- `range` in countdown mode: 1 while `min`≥1, 0 when `min`=0, so the final minute is shown in SS.cc.
- Display mapping:
  - `range`=0: `hex` = {`sec`, `cs`}.
  - `range`=1: `hex` = {`min`, `sec`}.
- Priority when pulses coincide: `rst` > `clear` > `load` > `start_stop` > `lap`.
  - `clear` together with `start_stop` leaves the block stopped at zero.
- `mode` is latched internally on `clear`, on `load`, and on a `start_stop` that starts counting. Changing `mode` while running has no effect.

## Timing
- Reset values of all outputs: `hex`=0000, `range`=0, `running`=0, `alarm`=0, `overflow`=0, `lap_active`=0.
- `running` rises or falls the cycle after the `start_stop` pulse.
- The first tick occurs DIV cycles after `running` rises, counted from a cleared prescaler.
- `hex` and `range` are registered: they update 1 cycle after the internal time update.
- `alarm` and `overflow` assert in the same cycle as the final time update.
- `clear` takes effect on the next edge. `hex` shows 0000 one cycle later.

## Configuration
- Macro: `STOPWATCH_LAP_EN`.
- Defined:
  - `lap` while running and not frozen: snapshot the display, set `lap_active`.
  - `lap` while running and frozen: refresh the snapshot.
  - `lap` while stopped: release, clear `lap_active`.
  - `clear` also releases.
  - Counting is unaffected by the freeze.
- Not defined: `lap` is ignored, `lap_active` is tied 0, and the display is always live.

## Structure
- Package `stopwatch_pkg`:
  - `mode_t` enum {MODE_UP, MODE_DOWN}.
  - `range_t` enum {RANGE_SS_CS, RANGE_MM_SS}.
  - `bcd_t` typedef (logic [3:0]).
  - `CS_PER_SEC`=100 constant.
  - `bcd_clamp59` function.
- Sub-module `bcd_mod_counter`:
  - Two BCD digits, parameter `MOD` (60 or 100), up/down enable.
  - Outputs: `carry` (up-wrap) and `borrow` (down-wrap).
  - Instantiated three times: `cs`, `sec`, `min`.

## Test plan
All scenarios use `CLK_HZ`=1000, so DIV=10.
- Start from reset, up mode → `hex`=0001 at 10 cycles + 1 register cycle. After 6000 ticks → `range`=1, `hex`=0100.
- Up mode, count to 59:59.99, then one more tick → `hex`=5959, `running`=0, `overflow`=1. A further `start_stop` is ignored.
- Countdown, `load` 00:02, start → `hex`=0199 after the first tick. After 200 ticks `hex`=0000, `alarm`=1, `running`=0.
- `load` with 75:99 → clamped; `hex`=5959 with `range`=1.
- Start, stop at cycle 5, resume → next tick 5 cycles after `running` rises. `clear` coincident with `start_stop` → `running`=0, `hex`=0000.
- With `STOPWATCH_LAP_EN`: `lap` at 00.50 → `hex` holds 0050 while time reaches 01.00. Stop, then `lap` → `hex`=0100, `lap_active`=0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch/countdown timer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic {MODE_UP = 1'b0, MODE_DOWN = 1'b1} mode_t;
  typedef enum logic {RANGE_SS_CS = 1'b0, RANGE_MM_SS = 1'b1} range_t;
  typedef logic [3:0] bcd_t;

  localparam int CS_PER_SEC = 100;

  // Two-digit BCD value limited to 59; any invalid BCD digit also maps to 59.
  function automatic logic [7:0] bcd_clamp59(input logic [7:0] v);
    if (v[7:4] > 4'd5 || v[3:0] > 4'd9) begin
      return 8'h59;
    end
    return v;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter (MOD 60 or 100) with synchronous clear/load and up/down step.
// Latency: value updates on the edge after an enable; carry/borrow are combinational.
// Backpressure: none; one step per enabled cycle.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr          zero the count (priority over ld and steps)
//   ld, ld_val   load a two-digit BCD value
//   up_en, dn_en step up / down (up wins if both)
//   value        current count {tens, units}
//   carry        up step wrapping MOD-1 -> 0 this cycle
//   borrow       down step wrapping 0 -> MOD-1 this cycle
module bcd_mod_counter #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       up_en,
  input  logic       dn_en,
  output logic [7:0] value,
  output logic       carry,
  output logic       borrow
);
  import stopwatch_pkg::*;

  localparam bcd_t TOP_HI = bcd_t'((MOD - 1) / 10);
  localparam bcd_t TOP_LO = bcd_t'((MOD - 1) % 10);

  bcd_t hi;
  bcd_t lo;
  logic at_top;
  logic at_zero;

  assign value   = {hi, lo};
  assign at_top  = (hi == TOP_HI) && (lo == TOP_LO);
  assign at_zero = (hi == 4'd0) && (lo == 4'd0);
  assign carry   = up_en && at_top;
  assign borrow  = dn_en && !up_en && at_zero;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hi <= 4'd0;
      lo <= 4'd0;
    end else if (ld) begin
      hi <= ld_val[7:4];
      lo <= ld_val[3:0];
    end else if (up_en) begin
      if (at_top) begin
        hi <= 4'd0;
        lo <= 4'd0;
      end else if (lo == 4'd9) begin
        hi <= hi + 4'd1;
        lo <= 4'd0;
      end else begin
        lo <= lo + 4'd1;
      end
    end else if (dn_en) begin
      if (at_zero) begin
        hi <= TOP_HI;
        lo <= TOP_LO;
      end else if (lo == 4'd0) begin
        hi <= hi - 4'd1;
        lo <= 4'd9;
      end else begin
        lo <= lo - 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_timer.sv
// BCD stopwatch / countdown timer with centisecond resolution and auto-ranging 4-digit display.
// Latency: running follows start_stop by 1 cycle; hex/range lag the internal time by 1 cycle.
// Backpressure: none; single-cycle control pulses accepted every cycle.
// Optional feature: define STOPWATCH_LAP_EN for lap freeze of the display.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode                0 = up, 1 = countdown (latched on clear, load, and start)
//   start_stop          toggle running
//   clear               zero time, stop, clear flags (and release lap)
//   load, load_mm/ss    load countdown preset MM:SS (stopped, mode=1 only)
//   lap                 lap freeze / refresh / release
//   hex[3:0]            display digits, hex[3] leftmost
//   range               0 = SS.cc, 1 = MM:SS
//   running, alarm, overflow, lap_active  status
module stopwatch_timer #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic            start_stop,
  input  logic            clear,
  input  logic            load,
  input  logic [7:0]      load_mm,
  input  logic [7:0]      load_ss,
  input  logic            lap,
  output logic [3:0][3:0] hex,
  output logic            range,
  output logic            running,
  output logic            alarm,
  output logic            overflow,
  output logic            lap_active
);
  import stopwatch_pkg::*;

  localparam int DIV = CLK_HZ / CS_PER_SEC;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic [7:0]    cs;
  logic [7:0]    sec;
  logic [7:0]    min;
  mode_t         mode_in;
  mode_t         mode_q;
  logic          tick;
  logic          at_max;
  logic          time_zero;
  logic          time_one;
  logic          load_ok;
  logic          cs_up;
  logic          cs_dn;
  logic          cs_carry;
  logic          cs_borrow;
  logic          sec_carry;
  logic          sec_borrow;
  logic          unused_min_carry;
  logic          unused_min_borrow;
  logic          range_sticky;
  range_t        range_live;
  range_t        range_q;
  logic [15:0]   disp_live;
  logic [15:0]   hex_live_q;

  assign mode_in   = mode_t'(mode);
  assign tick      = running && (presc == PW'(DIV - 1));
  assign at_max    = (min == 8'h59) && (sec == 8'h59) && (cs == 8'h99);
  assign time_zero = (min == 8'h00) && (sec == 8'h00) && (cs == 8'h00);
  assign time_one  = (min == 8'h00) && (sec == 8'h00) && (cs == 8'h01);
  assign load_ok   = load && !running && (mode_in == MODE_DOWN);

  // A saturating up tick and a tick at zero leave the time untouched.
  assign cs_up = tick && (mode_q == MODE_UP) && !at_max;
  assign cs_dn = tick && (mode_q == MODE_DOWN) && !time_zero;

  bcd_mod_counter #(.MOD(CS_PER_SEC)) u_cs (
    .clk(clk), .rst(rst), .clr(clear), .ld(load_ok), .ld_val(8'h00),
    .up_en(cs_up), .dn_en(cs_dn), .value(cs), .carry(cs_carry), .borrow(cs_borrow)
  );

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk(clk), .rst(rst), .clr(clear), .ld(load_ok), .ld_val(bcd_clamp59(load_ss)),
    .up_en(cs_carry), .dn_en(cs_borrow), .value(sec), .carry(sec_carry), .borrow(sec_borrow)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk(clk), .rst(rst), .clr(clear), .ld(load_ok), .ld_val(bcd_clamp59(load_mm)),
    .up_en(sec_carry), .dn_en(sec_borrow), .value(min),
    .carry(unused_min_carry), .borrow(unused_min_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      running      <= 1'b0;
      alarm        <= 1'b0;
      overflow     <= 1'b0;
      presc        <= '0;
      mode_q       <= MODE_UP;
      range_sticky <= 1'b0;
    end else if (clear) begin
      running      <= 1'b0;
      alarm        <= 1'b0;
      overflow     <= 1'b0;
      presc        <= '0;
      mode_q       <= mode_in;
      range_sticky <= 1'b0;
    end else begin
      // Prescaler holds while stopped so a resume continues the partial tick.
      if (running) begin
        presc <= tick ? '0 : presc + PW'(1);
      end
      if ((mode_q == MODE_UP) && (min != 8'h00)) begin
        range_sticky <= 1'b1;
      end
      if (tick && (mode_q == MODE_UP) && at_max) begin
        running  <= 1'b0;
        overflow <= 1'b1;
      end
      if (tick && (mode_q == MODE_DOWN) && time_one) begin
        running <= 1'b0;
        alarm   <= 1'b1;
      end
      if (load_ok) begin
        presc  <= '0;
        alarm  <= 1'b0;
        mode_q <= mode_in;
      end else if (start_stop) begin
        if (running) begin
          running <= 1'b0;
        end else if (!overflow && !((mode_in == MODE_DOWN) && time_zero)) begin
          running <= 1'b1;
          mode_q  <= mode_in;
        end
      end
    end
  end

  // Up mode keeps MM:SS once a minute has elapsed; countdown drops back to
  // SS.cc for the final minute.
  always_comb begin
    range_live = RANGE_SS_CS;
    if (mode_q == MODE_DOWN) begin
      if (min != 8'h00) range_live = RANGE_MM_SS;
    end else begin
      if (range_sticky || (min != 8'h00)) range_live = RANGE_MM_SS;
    end
    disp_live = (range_live == RANGE_MM_SS) ? {min, sec} : {sec, cs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_live_q <= 16'h0000;
      range_q    <= RANGE_SS_CS;
    end else begin
      hex_live_q <= disp_live;
      range_q    <= range_live;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [15:0] snap_hex;
  range_t      snap_range;
  logic        lap_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lap_q      <= 1'b0;
      snap_hex   <= 16'h0000;
      snap_range <= RANGE_SS_CS;
    end else if (lap && !load_ok && !start_stop) begin
      if (running) begin
        snap_hex   <= hex_live_q;
        snap_range <= range_q;
        lap_q      <= 1'b1;
      end else begin
        lap_q <= 1'b0;
      end
    end
  end

  assign hex        = lap_q ? snap_hex : hex_live_q;
  assign range      = lap_q ? (snap_range == RANGE_MM_SS) : (range_q == RANGE_MM_SS);
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign hex        = hex_live_q;
  assign range      = (range_q == RANGE_MM_SS);
  assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_timer.sv
// Directed self-checking bench for stopwatch_timer at CLK_HZ=1000 (10 cycles per tick).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// Covers reset, up count, countdown/alarm, clamp, overflow, range, pause/resume, clear priority, lap.
module tb_stopwatch_timer;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mode = 1'b0;
  logic            start_stop = 1'b0;
  logic            clear = 1'b0;
  logic            load = 1'b0;
  logic [7:0]      load_mm = 8'h00;
  logic [7:0]      load_ss = 8'h00;
  logic            lap = 1'b0;
  logic [3:0][3:0] hex;
  logic            range;
  logic            running;
  logic            alarm;
  logic            overflow;
  logic            lap_active;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stopwatch_timer #(.CLK_HZ(1000)) dut (
    .clk(clk), .rst(rst), .mode(mode), .start_stop(start_stop), .clear(clear),
    .load(load), .load_mm(load_mm), .load_ss(load_ss), .lap(lap),
    .hex(hex), .range(range), .running(running), .alarm(alarm),
    .overflow(overflow), .lap_active(lap_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ss();
    start_stop = 1'b1; step(1); start_stop = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1; step(1); clear = 1'b0;
  endtask

  task automatic ld(input logic [7:0] mm, input logic [7:0] s);
    load_mm = mm; load_ss = s; load = 1'b1; step(1); load = 1'b0;
  endtask

  task automatic lp();
    lap = 1'b1; step(1); lap = 1'b0;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    check("rst_hex", 32'(hex), 32'h0000);
    check("rst_range", 32'(range), 0);
    check("rst_running", 32'(running), 0);
    check("rst_alarm", 32'(alarm), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_lap_active", 32'(lap_active), 0);

    // Up count: first tick 10 cycles after running rises, display one cycle later.
    mode = 1'b0;
    ss();
    check("up_running", 32'(running), 1);
    step(10);
    check("up_hex_pre_tick", 32'(hex), 32'h0000);
    step(1);
    check("up_hex_first", 32'(hex), 32'h0001);
    step(990);
    check("up_hex_1s", 32'(hex), 32'h0100);
    check("up_range_1s", 32'(range), 0);
    ss();
    check("up_stop", 32'(running), 0);
    clr();
    check("clr_hex_lag", 32'(hex), 32'h0100);
    step(1);
    check("clr_hex", 32'(hex), 32'h0000);

    // Countdown from 00:02.
    mode = 1'b1;
    ld(8'h00, 8'h02);
    step(1);
    check("dn_load_hex", 32'(hex), 32'h0200);
    check("dn_load_range", 32'(range), 0);
    ss();
    check("dn_running", 32'(running), 1);
    step(11);
    check("dn_hex_first", 32'(hex), 32'h0199);
    step(1989);
    check("dn_alarm", 32'(alarm), 1);
    check("dn_running_end", 32'(running), 0);
    step(1);
    check("dn_hex_zero", 32'(hex), 32'h0000);
    ss();
    check("dn_ss_ignored", 32'(running), 0);
    check("dn_alarm_kept", 32'(alarm), 1);

    // Clamped preset 75:99 -> 59:59.
    ld(8'h75, 8'h99);
    check("clamp_alarm_clr", 32'(alarm), 0);
    step(1);
    check("clamp_hex", 32'(hex), 32'h5959);
    check("clamp_range", 32'(range), 1);

    // Up from 59:59.00 to saturation.
    mode = 1'b0;
    ss();
    step(999);
    check("ovf_running_pre", 32'(running), 1);
    check("ovf_flag_pre", 32'(overflow), 0);
    step(1);
    check("ovf_running", 32'(running), 0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_hex", 32'(hex), 32'h5959);
    ss();
    step(1);
    check("ovf_ss_ignored", 32'(running), 0);

    // Up-mode range latches once a minute is reached.
    clr();
    mode = 1'b1;
    ld(8'h00, 8'h59);
    mode = 1'b0;
    ss();
    step(1000);
    check("rng_hex_pre", 32'(hex), 32'h5999);
    check("rng_range_pre", 32'(range), 0);
    step(1);
    check("rng_hex", 32'(hex), 32'h0100);
    check("rng_range", 32'(range), 1);

    // Pause after 5 prescaler counts; the resumed tick lands 5 cycles later.
    clr();
    ss();
    step(4);
    ss();
    check("pause_stopped", 32'(running), 0);
    step(3);
    ss();
    check("resume_running", 32'(running), 1);
    step(5);
    check("resume_hex_lag", 32'(hex), 32'h0000);
    step(1);
    check("resume_hex", 32'(hex), 32'h0001);

    // clear beats start_stop while stopped at non-zero time.
    ss();
    clear = 1'b1; start_stop = 1'b1;
    step(1);
    clear = 1'b0; start_stop = 1'b0;
    check("clr_ss_running", 32'(running), 0);
    step(1);
    check("clr_ss_hex", 32'(hex), 32'h0000);

    // Lap behaviour.
    mode = 1'b0;
    ss();
    step(501);
    check("lap_hex_050", 32'(hex), 32'h0050);
    lp();
`ifdef STOPWATCH_LAP_EN
    check("lap_active_set", 32'(lap_active), 1);
    check("lap_hex_frozen", 32'(hex), 32'h0050);
    step(500);
    check("lap_hex_held", 32'(hex), 32'h0050);
    ss();
    lp();
    check("lap_released", 32'(lap_active), 0);
    check("lap_hex_live", 32'(hex), 32'h0100);
`else
    check("lap_ignored", 32'(lap_active), 0);
    check("lap_hex_live1", 32'(hex), 32'h0050);
    step(500);
    check("lap_hex_live2", 32'(hex), 32'h0100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
